// File: rtl/bus_bridge.sv
// CPU memory-bus bridge: routes accesses to DRAM or to LED/switch/button/display/timer registers,
// and scans an 8-digit seven-segment display from the digit register.
module bus_bridge #(
  parameter int SCAN_DIV = 20000,
  parameter int DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_we,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam logic [31:0] A_PERIPH = 32'hFFFF_F000;
  localparam logic [31:0] A_DIG    = 32'hFFFF_F000;
  localparam logic [31:0] A_TCNT   = 32'hFFFF_F020;
  localparam logic [31:0] A_TDIV   = 32'hFFFF_F024;
  localparam logic [31:0] A_LED    = 32'hFFFF_F060;
  localparam logic [31:0] A_SW     = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN    = 32'hFFFF_F078;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              in_dram;
  logic              wr_dig, wr_tcnt, wr_tdiv, wr_led;
  logic [31:0]       digit_reg;
  logic [31:0]       tcnt, tdiv, presc;
  logic [23:0]       sw_meta, sw_sync;
  logic [4:0]        btn_meta, btn_sync;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        dig_idx;
  logic [3:0]        nibble;

  assign in_dram = Bus_addr < A_PERIPH;
  assign wr_dig  = Bus_we && (Bus_addr == A_DIG);
  assign wr_tcnt = Bus_we && (Bus_addr == A_TCNT);
  assign wr_tdiv = Bus_we && (Bus_addr == A_TDIV);
  assign wr_led  = Bus_we && (Bus_addr == A_LED);

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_we    = Bus_we && in_dram;

  always_comb begin
    Bus_rdata = 32'h0;
    if (in_dram) begin
      Bus_rdata = dram_rdata;
    end else begin
      case (Bus_addr)
        A_DIG:   Bus_rdata = digit_reg;
        A_TCNT:  Bus_rdata = tcnt;
        A_TDIV:  Bus_rdata = tdiv;
        A_LED:   Bus_rdata = {8'h0, led};
        A_SW:    Bus_rdata = {8'h0, sw_sync};
        A_BTN:   Bus_rdata = {27'h0, btn_sync};
        default: Bus_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      led       <= '0;
      digit_reg <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
      if (wr_led) led <= Bus_wdata[23:0];
      if (wr_dig) digit_reg <= Bus_wdata;
    end
  end

  // Bus writes are applied last so they override a same-cycle terminal-count increment.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      tcnt  <= '0;
      tdiv  <= '0;
      presc <= '0;
    end else begin
      if (tdiv != 32'h0) begin
        if (presc == tdiv - 32'h1) begin
          presc <= '0;
          tcnt  <= tcnt + 32'h1;
        end else begin
          presc <= presc + 32'h1;
        end
      end
      if (wr_tdiv) begin
        tdiv  <= Bus_wdata;
        presc <= '0;
      end
      if (wr_tcnt) begin
        tcnt  <= Bus_wdata;
        presc <= '0;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign dig_en = ~(8'h01 << dig_idx);
  assign nibble = digit_reg[{dig_idx, 2'b00} +: 4];

  always_comb begin
    dig_seg = 8'hFF;
    case (nibble)
      4'h0: dig_seg = 8'hC0;
      4'h1: dig_seg = 8'hF9;
      4'h2: dig_seg = 8'hA4;
      4'h3: dig_seg = 8'hB0;
      4'h4: dig_seg = 8'h99;
      4'h5: dig_seg = 8'h92;
      4'h6: dig_seg = 8'h82;
      4'h7: dig_seg = 8'hF8;
      4'h8: dig_seg = 8'h80;
      4'h9: dig_seg = 8'h90;
      4'hA: dig_seg = 8'h88;
      4'hB: dig_seg = 8'h83;
      4'hC: dig_seg = 8'hC6;
      4'hD: dig_seg = 8'hA1;
      4'hE: dig_seg = 8'h86;
      4'hF: dig_seg = 8'h8E;
      default: dig_seg = 8'hFF;
    endcase
  end

endmodule
